seq_serializer: RTL and testbench

Upstream feeder for the serial sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which drives the detector's `din`. A one-word holding buffer lets back-to-back words stream with no idle bit between them. When no word is available it drives a fixed idle level, so gaps are visible to the detector as a known bit value.

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_serializer_if.sv | 20 ++
 rtl/seq_word_buf.sv | 40 ++++
 rtl/seq_serializer.sv | 133 +++++++++++++
 tb/tb_seq_serializer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serializer and the downstream sequence detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Target pattern of the detector fed by dout, oldest bit in the MSB position.
    localparam int unsigned                DET_PATTERN_LEN = 6;
    localparam logic [DET_PATTERN_LEN-1:0] DET_PATTERN     = 6'b101110;

endpackage

// File: rtl/seq_serializer_if.sv
// Parallel-word valid/ready handshake into the serializer.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/seq_word_buf.sv
// Single-entry holding register; a write takes priority over a same-cycle read.
module seq_word_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] d,
    output logic             full,
    output logic [WIDTH-1:0] q
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (rd_en) begin
            full_d = 1'b0;
        end
        if (wr_en) begin
            full_d = 1'b1;
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign q    = data_q;
endmodule

// File: rtl/seq_serializer.sv
// Word-to-bit serializer with one-word holding buffer for gapless streaming.
// Bit order: MSB first; define SEQ_SERIALIZER_LSB_FIRST_EN for LSB first.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_serializer_if.slave         in_if,
    output logic                    dout,
    output logic                    dout_valid,
    output logic                    busy
);
    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
        return w[0];
`else
        return w[WIDTH-1];
`endif
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
        return {1'b0, w[WIDTH-1:1]};
`else
        return {w[WIDTH-2:0], 1'b0};
`endif
    endfunction

    ser_state_t       state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic             buf_full, buf_wr, buf_rd;
    logic [WIDTH-1:0] buf_word;
    logic             accept, load;
    logic [WIDTH-1:0] load_word;

    seq_word_buf #(
        .WIDTH (WIDTH)
    ) u_word_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (buf_wr),
        .rd_en (buf_rd),
        .d     (in_if.data_in),
        .full  (buf_full),
        .q     (buf_word)
    );

    assign in_if.data_ready = !buf_full;
    assign accept           = in_if.data_valid && !buf_full;

    // dout holds the bit currently on the wire; shreg holds the bits still to come.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        buf_wr       = 1'b0;
        buf_rd       = 1'b0;
        load         = 1'b0;
        load_word    = in_if.data_in;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (buf_full) begin
                        buf_rd    = 1'b1;
                        load      = 1'b1;
                        load_word = buf_word;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        bit_cnt_d    = '0;
                        dout_d       = IDLE_BIT;
                        dout_valid_d = 1'b0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    dout_d    = first_bit(shreg_q);
                    shreg_d   = shift_out(shreg_q);
                    buf_wr    = accept;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            bit_cnt_d    = '0;
            dout_d       = first_bit(load_word);
            shreg_d      = shift_out(load_word);
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == SHIFT) || buf_full;
endmodule

// File: tb/tb_seq_serializer.sv
// Directed, table-driven bench for seq_serializer (honours SEQ_SERIALIZER_LSB_FIRST_EN).
module tb_seq_serializer;
    import seq_pkg::*;

    typedef struct {
        logic [7:0]  word;
        logic [7:0]  seq;   // expected dout order, leftmost bit first
        int unsigned hits;  // detector pattern occurrences within the word
    } vec_t;

    logic clk;
    logic rst_n;
    logic dout, dout_valid, busy;

    int unsigned n_pass;
    int unsigned n_total;
    vec_t        tbl[5];

    seq_serializer_if #(.WIDTH(8)) bus ();

    seq_serializer #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (bus),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle: dout=0, dout_valid=0, busy=0, data_ready=1
    task automatic check_idle(input string name);
        check(name, {dout, dout_valid, busy, bus.data_ready}, 4'b0001);
    endtask

    task automatic send_single(input vec_t v);
        logic [5:0]  hist;
        int unsigned hits;
        hist = '0;
        hits = 0;
        bus.data_in    = v.word;
        bus.data_valid = 1'b1;
        check("ready_before_accept", bus.data_ready, 1);
        tick();
        bus.data_valid = 1'b0;
        bus.data_in    = ~v.word;
        for (int i = 0; i < 8; i++) begin
            check("single_bit", {busy, dout_valid, dout}, {2'b11, v.seq[7-i]});
            hist = {hist[4:0], dout};
            if (i >= 5 && hist == DET_PATTERN) hits++;
            tick();
        end
        check_idle("single_after_word");
        check("det_hits", hits, v.hits);
        tick();
    endtask

    // Producer holds data_valid high; ready expectation is the buffer-full window.
    task automatic stream(input int nw, input vec_t a, input vec_t b, input vec_t c);
        logic [7:0] words[3];
        logic [7:0] seqs[3];
        int         idx;
        logic       fire;
        logic       exp_ready;
        words = '{a.word, b.word, c.word};
        seqs  = '{a.seq, b.seq, c.seq};
        bus.data_in    = words[0];
        bus.data_valid = 1'b1;
        tick();
        idx         = 1;
        bus.data_in = words[1];
        for (int i = 0; i < 8*nw; i++) begin
            check("stream_bit", {busy, dout_valid, dout}, {2'b11, seqs[i/8][7-(i%8)]});
            exp_ready = !((i % 8) != 0 && i < 8*(nw-1));
            check("stream_ready", bus.data_ready, exp_ready);
            fire = bus.data_valid && bus.data_ready;
            tick();
            if (fire) begin
                idx++;
                if (idx < nw) bus.data_in = words[idx];
                else begin
                    bus.data_valid = 1'b0;
                    bus.data_in    = 8'h00;
                end
            end
        end
        check("stream_all_accepted", idx, nw);
        check_idle("stream_after");
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
        tbl[0] = '{8'h1D, 8'b1011_1000, 1};
        tbl[1] = '{8'h3A, 8'b0101_1100, 1};
        tbl[2] = '{8'hFF, 8'b1111_1111, 0};
        tbl[3] = '{8'h01, 8'b1000_0000, 0};
        tbl[4] = '{8'h80, 8'b0000_0001, 0};
`else
        tbl[0] = '{8'hB8, 8'b1011_1000, 1};
        tbl[1] = '{8'h5C, 8'b0101_1100, 1};
        tbl[2] = '{8'hFF, 8'b1111_1111, 0};
        tbl[3] = '{8'h01, 8'b0000_0001, 0};
        tbl[4] = '{8'h80, 8'b1000_0000, 0};
`endif
        rst_n          = 1'b0;
        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;
        #1;
        check_idle("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_idle("idle_after_reset");
            tick();
        end

        for (int i = 0; i < 5; i++) send_single(tbl[i]);

        stream(2, tbl[0], tbl[1], tbl[2]);
        stream(3, tbl[0], tbl[1], tbl[3]);

        // Reset asserted while the 4th bit is on the wire.
        bus.data_in    = tbl[0].word;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("pre_reset_bit", {dout_valid, dout}, {1'b1, tbl[0].seq[7-i]});
            if (i < 3) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_word");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("after_reset_release");
        send_single(tbl[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
